// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
// Module      : piso_pkg
// Description : Shared types and sizing helpers for the PISO serializer.
//               Frame length depends on macro PISO_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package piso_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int frame_len(input int width);
`ifdef PISO_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/piso_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer_if
// Description : Load/ready handshake and serial output bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             load;
    logic             ready;
    logic             sout;
    logic             frame;
    logic             busy;
    logic             done;

    modport master (
        output din, load,
        input  ready, sout, frame, busy, done
    );

    modport slave (
        input  din, load,
        output ready, sout, frame, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/piso_shift_core.sv
`default_nettype none
// ============================================================================
// Module      : piso_shift_core
// Description : Shift register with bit-order selection and registered sout.
//               Optional parity bit storage under PISO_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_shift_core #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic             i_shift,
    input  wire logic             i_clear,
`ifdef PISO_PARITY_EN
    input  wire logic             i_par_sel,
`endif
    input  wire logic [WIDTH-1:0] i_din,
    output logic                  o_sout
);

    // The first bit goes straight to r_sout, so only WIDTH-1 bits are held.
    logic [WIDTH-2:0] r_sh;
    logic             r_sout;
    logic             w_first;
    logic             w_next;
    logic [WIDTH-2:0] w_load_rest;
    logic [WIDTH-2:0] w_shift_rest;
`ifdef PISO_PARITY_EN
    logic             r_par;
`endif

    generate
        if (MSB_FIRST) begin : g_msb
            assign w_first      = i_din[WIDTH-1];
            assign w_load_rest  = i_din[WIDTH-2:0];
            assign w_next       = r_sh[WIDTH-2];
            assign w_shift_rest = r_sh << 1;
        end else begin : g_lsb
            assign w_first      = i_din[0];
            assign w_load_rest  = i_din[WIDTH-1:1];
            assign w_next       = r_sh[0];
            assign w_shift_rest = r_sh >> 1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_sh   <= '0;
            r_sout <= 1'b0;
`ifdef PISO_PARITY_EN
            r_par  <= 1'b0;
`endif
        end else if (i_load) begin
            r_sh   <= w_load_rest;
            r_sout <= w_first;
`ifdef PISO_PARITY_EN
            r_par  <= ^i_din;
`endif
        end else if (i_shift) begin
            r_sh   <= w_shift_rest;
`ifdef PISO_PARITY_EN
            r_sout <= i_par_sel ? r_par : w_next;
`else
            r_sout <= w_next;
`endif
        end
    end

    assign o_sout = r_sout;

endmodule
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer
// Description : Parallel-in / serial-out transmitter with frame/done markers.
//               Optional trailing even-parity bit under PISO_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire logic       clk,
    input  wire logic       reset,
    piso_serializer_if.slave bus
);

    localparam int                 c_frame_len = frame_len(WIDTH);
    localparam int                 c_cnt_w     = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last      = c_cnt_w'(c_frame_len - 1);

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_frame;
    logic               r_busy;
    logic               r_done;

    logic               w_last;
    logic               w_ready;
    logic               w_accept;
    logic               w_sout;

    assign w_last   = (r_state == SHIFT) && (r_cnt == c_last);
    assign w_ready  = (r_state == IDLE) || w_last;
    assign w_accept = bus.load && w_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_frame <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_frame <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= SHIFT;
                        r_cnt   <= '0;
                        r_frame <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_last) begin
                        r_cnt <= '0;
                        if (w_accept) begin
                            r_frame <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                        r_done <= ((r_cnt + 1'b1) == c_last);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    piso_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk       (clk),
        .rst       (reset),
        .i_load    (w_accept),
        .i_shift   ((r_state == SHIFT) && !w_last),
        .i_clear   (w_last && !w_accept),
`ifdef PISO_PARITY_EN
        .i_par_sel (r_cnt == c_cnt_w'(WIDTH - 1)),
`endif
        .i_din     (bus.din),
        .o_sout    (w_sout)
    );

    assign bus.ready = w_ready;
    assign bus.sout  = w_sout;
    assign bus.frame = r_frame;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_serializer
// Description : Scoreboard bench driving an MSB-first and an LSB-first DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    typedef struct packed {
        logic sout;
        logic frame;
        logic done;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   check_en = 1'b0;
    exp_t q_m[$];
    exp_t q_l[$];

    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(W)) if_m ();
    piso_serializer_if #(.WIDTH(W)) if_l ();

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk   (clk),
        .reset (reset),
        .bus   (if_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk   (clk),
        .reset (reset),
        .bus   (if_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic push_word(input logic [W-1:0] d);
        exp_t e;
        for (int i = 0; i < FL; i++) begin
            e.frame = (i == 0);
            e.done  = (i == FL - 1);
            e.sout  = (i == W) ? ^d : d[W-1-i];
            q_m.push_back(e);
            e.sout  = (i == W) ? ^d : d[i];
            q_l.push_back(e);
        end
    endtask

    task automatic check_dut(input string nm, input bit has, input exp_t e,
                             input logic so, input logic fr, input logic dn, input logic bz);
        check({nm, ".sout"},  {31'd0, so}, {31'd0, has ? e.sout  : 1'b0});
        check({nm, ".frame"}, {31'd0, fr}, {31'd0, has ? e.frame : 1'b0});
        check({nm, ".done"},  {31'd0, dn}, {31'd0, has ? e.done  : 1'b0});
        check({nm, ".busy"},  {31'd0, bz}, {31'd0, has});
    endtask

    // One clock: drive inputs, check ready, advance the scoreboard, check outputs.
    task automatic step(input bit r, input bit ld, input logic [W-1:0] d);
        bit exp_ready;
        reset     = r;
        if_m.load = ld;
        if_m.din  = d;
        if_l.load = ld;
        if_l.din  = d;
        exp_ready = (q_m.size() <= 1);
        if (check_en) begin
            check("m.ready", {31'd0, if_m.ready}, {31'd0, exp_ready});
            check("l.ready", {31'd0, if_l.ready}, {31'd0, exp_ready});
        end
        @(posedge clk);
        #1;
        if (r) begin
            q_m.delete();
            q_l.delete();
            check_en = 1'b1;
        end else begin
            if (q_m.size() != 0) void'(q_m.pop_front());
            if (q_l.size() != 0) void'(q_l.pop_front());
            if (ld && exp_ready) push_word(d);
        end
        if (check_en) begin
            check_dut("m", q_m.size() != 0, (q_m.size() != 0) ? q_m[0] : '0,
                      if_m.sout, if_m.frame, if_m.done, if_m.busy);
            check_dut("l", q_l.size() != 0, (q_l.size() != 0) ? q_l[0] : '0,
                      if_l.sout, if_l.frame, if_l.done, if_l.busy);
        end
    endtask

    initial begin
        reset     = 1'b1;
        if_m.load = 1'b0;
        if_m.din  = '0;
        if_l.load = 1'b0;
        if_l.din  = '0;
        #1;

        // Reset then idle
        repeat (2) step(1'b1, 1'b0, 8'h00);
        repeat (3) step(1'b0, 1'b0, 8'h00);

        // Single word
        step(1'b0, 1'b1, 8'hA5);
        repeat (FL + 2) step(1'b0, 1'b0, 8'h00);

        // Back-to-back, second word presented in the last-bit cycle
        step(1'b0, 1'b1, 8'hA5);
        repeat (FL - 1) step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h3C);
        repeat (FL + 2) step(1'b0, 1'b0, 8'h00);

        // Load while busy is ignored
        step(1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b0, 8'h00);
        repeat (6) step(1'b0, 1'b1, 8'h00);
        repeat (FL) step(1'b0, 1'b0, 8'h00);

        // Reset mid-frame, then a clean word
        step(1'b0, 1'b1, 8'hA5);
        repeat (3) step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h55);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h0F);
        repeat (FL + 2) step(1'b0, 1'b0, 8'h00);

        // Odd-parity word and single-bit word
        step(1'b0, 1'b1, 8'h07);
        repeat (FL + 1) step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h01);
        repeat (FL + 1) step(1'b0, 1'b0, 8'h00);

        // Load held high with changing data
        repeat (4 * FL) step(1'b0, 1'b1, 8'($urandom));
        repeat (FL + 2) step(1'b0, 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
